// File: rtl/cla_adder_pipe_if.sv
// Operand/result handshake bundle for the pipelined CLA adder/subtractor.
// Latency: none (wires only).
// Backpressure: in_ready/out_ready carry valid-ready flow control in each direction.
interface cla_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    // Producer/consumer side: drives operands and out_ready, sees results.
    modport master (
        output in_valid, x, y, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf, zero
    );

    // Adder side.
    modport slave (
        input  in_valid, x, y, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor with overflow and zero flags.
// Latency: result registered one edge after operand acceptance (s1, then s2 drives outputs).
// Backpressure: in_ready = !s1_valid || !out_valid || out_ready; outputs hold while stalled.
module cla_adder_pipe #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    cla_adder_pipe_if.slave    bus
);
    localparam int NB = WIDTH / 4;   // 4-bit blocks
    localparam int NS = WIDTH / 16;  // super-groups of 4 blocks

    if ((WIDTH % 16) != 0 || WIDTH < 16) begin : g_width_check
        $error("cla_adder_pipe: WIDTH must be a positive multiple of 16");
    end

    // ---------------- stage 1 combinational: P/G and block lookahead ----------------
    logic [WIDTH-1:0]     y_eff;
    logic [WIDTH-1:0]     p_d;
    logic [WIDTH-1:0]     g_d;
    logic                 c0_d;
    logic [NB-1:0]        gb_d;
    logic [NB-1:0]        pb_d;
    logic [NB-1:0][2:0]   ci0_d;   // block-internal carries c3..c1 assuming block carry-in 0
    logic [NB-1:0][2:0]   ci1_d;   // same, assuming block carry-in 1
    logic [3:0]           s1_bp;
    logic [3:0]           s1_bg;

    // Invert Y for subtract, then per-block group G/P and both carry-select candidates.
    always_comb begin
        y_eff = bus.sub ? ~bus.y : bus.y;
        c0_d  = bus.sub | bus.cin;
        p_d   = bus.x ^ y_eff;
        g_d   = bus.x & y_eff;
        gb_d  = '0;
        pb_d  = '0;
        ci0_d = '0;
        ci1_d = '0;
        s1_bp = '0;
        s1_bg = '0;
        for (int k = 0; k < NB; k++) begin
            s1_bp = p_d[4*k +: 4];
            s1_bg = g_d[4*k +: 4];
            gb_d[k] = s1_bg[3] | (s1_bp[3] & s1_bg[2]) | (s1_bp[3] & s1_bp[2] & s1_bg[1])
                    | (s1_bp[3] & s1_bp[2] & s1_bp[1] & s1_bg[0]);
            pb_d[k] = &s1_bp;
            ci0_d[k] = {s1_bg[2] | (s1_bp[2] & s1_bg[1]) | (s1_bp[2] & s1_bp[1] & s1_bg[0]),
                        s1_bg[1] | (s1_bp[1] & s1_bg[0]),
                        s1_bg[0]};
            ci1_d[k] = {s1_bg[2] | (s1_bp[2] & s1_bg[1]) | (s1_bp[2] & s1_bp[1] & s1_bg[0])
                                 | (s1_bp[2] & s1_bp[1] & s1_bp[0]),
                        s1_bg[1] | (s1_bp[1] & s1_bg[0]) | (s1_bp[1] & s1_bp[0]),
                        s1_bg[0] | s1_bp[0]};
        end
    end

    // ---------------- pipeline control ----------------
    logic s1_valid;
    logic out_valid_q;
    logic s2_adv;
    logic s1_adv;

    assign s2_adv       = !out_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    // ---------------- stage 1 registers ----------------
    logic [WIDTH-1:0]   s1_p;
    logic               s1_c0;
    logic [NB-1:0]      s1_gb;
    logic [NB-1:0]      s1_pb;
    logic [NB-1:0][2:0] s1_ci0;
    logic [NB-1:0][2:0] s1_ci1;

    // s1 occupancy: refilled (or emptied) whenever the stage can advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
        end
    end

    // s1 payload: captured only on an input transfer, held otherwise.
    always_ff @(posedge clk) begin
        if (s1_adv && bus.in_valid) begin
            s1_p   <= p_d;
            s1_c0  <= c0_d;
            s1_gb  <= gb_d;
            s1_pb  <= pb_d;
            s1_ci0 <= ci0_d;
            s1_ci1 <= ci1_d;
        end
    end

    // ---------------- stage 2 combinational: super-group lookahead and select ----------------
    logic [WIDTH:0]   c;
    logic             cs;
    logic [3:0]       gs;
    logic [3:0]       ps;
    logic [3:0]       cb;
    logic [2:0]       sel;
    logic [WIDTH-1:0] sum_d;

    // Block carries by level-2 lookahead inside each super-group; super-group carries ripple.
    always_comb begin
        c   = '0;
        cs  = s1_c0;
        gs  = '0;
        ps  = '0;
        cb  = '0;
        sel = '0;
        for (int j = 0; j < NS; j++) begin
            gs = s1_gb[4*j +: 4];
            ps = s1_pb[4*j +: 4];
            cb[0] = cs;
            cb[1] = gs[0] | (ps[0] & cs);
            cb[2] = gs[1] | (ps[1] & gs[0]) | (ps[1] & ps[0] & cs);
            cb[3] = gs[2] | (ps[2] & gs[1]) | (ps[2] & ps[1] & gs[0]) | (ps[2] & ps[1] & ps[0] & cs);
            for (int i = 0; i < 4; i++) begin
                sel = cb[i] ? s1_ci1[4*j + i] : s1_ci0[4*j + i];
                c[16*j + 4*i +: 4] = {sel, cb[i]};
            end
            cs = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1]) | (ps[3] & ps[2] & ps[1] & gs[0])
               | ((&ps) & cs);
        end
        c[WIDTH] = cs;
        sum_d    = s1_p ^ c[WIDTH-1:0];
    end

    // ---------------- stage 2 registers (drive outputs) ----------------
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    // Output stage: loads from s1 when the consumer is not stalling it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b1;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            if (s1_valid) begin
                s_q    <= sum_d;
                cout_q <= c[WIDTH];
                ovf_q  <= c[WIDTH] ^ c[WIDTH-1];
                zero_q <= ~|sum_d;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: directed vectors at 16/32 bits, back-pressure,
// random streaming against a behavioural model at 64 bits, and reset mid-stream.
// Inputs driven on the falling edge, outputs sampled on the falling edge (+1 where noted).
module tb_cla_adder_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_adder_pipe_if #(.WIDTH(16)) i16 ();
    cla_adder_pipe_if #(.WIDTH(32)) i32 ();
    cla_adder_pipe_if #(.WIDTH(64)) i64 ();

    cla_adder_pipe #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));
    cla_adder_pipe #(.WIDTH(32)) u32 (.clk(clk), .rst_n(rst_n), .bus(i32.slave));
    cla_adder_pipe #(.WIDTH(64)) u64 (.clk(clk), .rst_n(rst_n), .bus(i64.slave));

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          w;
        logic [63:0] x;
        logic [63:0] y;
        logic        cin;
        logic        sub;
        logic [63:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    localparam int NVEC = 13;
    localparam int NSTREAM = 10000;
    vec_t vecs [NVEC];

    logic [66:0] exp_q [$];
    int          n_out;

    task automatic chk(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: {ovf, zero, cout, s} for X + (Sub ? ~Y : Y) + (Sub ? 1 : Cin).
    function automatic logic [66:0] model64(input logic [63:0] x, input logic [63:0] y,
                                            input logic cin, input logic sub);
        logic [63:0] ye;
        logic [64:0] r;
        logic        ov;
        ye = sub ? ~y : y;
        r  = {1'b0, x} + {1'b0, ye} + {64'd0, (sub ? 1'b1 : cin)};
        ov = (x[63] == ye[63]) && (r[63] != x[63]);
        return {ov, (r[63:0] == 64'd0), r[64], r[63:0]};
    endfunction

    task automatic read_out(input int w, output logic ov, output logic [63:0] s,
                            output logic co, output logic of, output logic z);
        if (w == 16) begin
            ov = i16.out_valid; s = {48'd0, i16.s}; co = i16.cout; of = i16.ovf; z = i16.zero;
        end else begin
            ov = i32.out_valid; s = {32'd0, i32.s}; co = i32.cout; of = i32.ovf; z = i32.zero;
        end
    endtask

    // One directed transaction on the 16- or 32-bit instance, with latency measured in edges.
    task automatic apply_vec(input vec_t v, input int idx);
        int          edges;
        logic        ov;
        logic [63:0] as;
        logic        ac, ao, az;
        @(negedge clk);
        i16.x = v.x[15:0]; i16.y = v.y[15:0]; i16.cin = v.cin; i16.sub = v.sub;
        i32.x = v.x[31:0]; i32.y = v.y[31:0]; i32.cin = v.cin; i32.sub = v.sub;
        i16.in_valid = (v.w == 16);
        i32.in_valid = (v.w == 32);
        @(negedge clk);
        i16.in_valid = 1'b0;
        i32.in_valid = 1'b0;
        edges = 1;
        read_out(v.w, ov, as, ac, ao, az);
        while (!ov && edges < 8) begin
            @(negedge clk);
            edges++;
            read_out(v.w, ov, as, ac, ao, az);
        end
        if (!ov) begin
            checks++;
            failures++;
            $display("FAIL vec%0d_timeout: out_valid=0 after %0d edges, required 1", idx, edges);
        end else begin
            chk($sformatf("vec%0d_latency", idx), 67'(edges), 67'd2);
            chk($sformatf("vec%0d_s", idx), 67'(as), 67'(v.s));
            chk($sformatf("vec%0d_cout", idx), 67'(ac), 67'(v.cout));
            chk($sformatf("vec%0d_ovf", idx), 67'(ao), 67'(v.ovf));
            chk($sformatf("vec%0d_zero", idx), 67'(az), 67'(v.zero));
        end
    endtask

    // One cycle on the 64-bit instance: drive, then account for both transfers of the next edge.
    task automatic step64(input logic iv, input logic [63:0] x, input logic [63:0] y,
                          input logic cin, input logic sub, input logic ordy, output logic acc);
        logic [66:0] a;
        logic [66:0] e;
        @(negedge clk);
        i64.in_valid = iv; i64.x = x; i64.y = y; i64.cin = cin; i64.sub = sub;
        i64.out_ready = ordy;
        #1;
        acc = iv && i64.in_ready;
        if (i64.out_valid && ordy) begin
            a = {i64.ovf, i64.zero, i64.cout, i64.s};
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got 0x%0h, required no result", a);
            end else begin
                e = exp_q.pop_front();
                n_out++;
                chk("stream_result", a, e);
            end
        end
        if (acc) exp_q.push_back(model64(x, y, cin, sub));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [63:0] bx [3];
        logic [63:0] by [3];
        logic        bsub [3];
        int          idx;
        int          sent;
        logic        have;
        logic [63:0] rx, ry;
        logic        rcin, rsub;

        //         w   x                 y                 cin   sub   s                 cout  ovf   zero
        vecs[0]  = '{16, 64'h1234,       64'h0FFF,       1'b1, 1'b0, 64'h2234,       1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16, 64'hFFFF,       64'h0000,       1'b1, 1'b0, 64'h0000,       1'b1, 1'b0, 1'b1};
        vecs[2]  = '{16, 64'h7FFF,       64'h0001,       1'b0, 1'b0, 64'h8000,       1'b0, 1'b1, 1'b0};
        vecs[3]  = '{16, 64'h0003,       64'h0003,       1'b1, 1'b1, 64'h0000,       1'b1, 1'b0, 1'b1};
        vecs[4]  = '{16, 64'h8000,       64'h8000,       1'b0, 1'b0, 64'h0000,       1'b1, 1'b1, 1'b1};
        vecs[5]  = '{16, 64'h0000,       64'h0001,       1'b0, 1'b1, 64'hFFFF,       1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16, 64'hAAAA,       64'h5555,       1'b1, 1'b0, 64'h0000,       1'b1, 1'b0, 1'b1};
        vecs[7]  = '{16, 64'h0F0F,       64'h00F1,       1'b0, 1'b0, 64'h1000,       1'b0, 1'b0, 1'b0};
        vecs[8]  = '{32, 64'h5,          64'h7,          1'b0, 1'b1, 64'hFFFFFFFE,   1'b0, 1'b0, 1'b0};
        vecs[9]  = '{32, 64'h80000000,   64'h1,          1'b0, 1'b1, 64'h7FFFFFFF,   1'b1, 1'b1, 1'b0};
        vecs[10] = '{32, 64'hFFFFFFFF,   64'hFFFFFFFF,   1'b1, 1'b0, 64'hFFFFFFFF,   1'b1, 1'b0, 1'b0};
        vecs[11] = '{32, 64'h12345678,   64'h12345678,   1'b0, 1'b1, 64'h00000000,   1'b1, 1'b0, 1'b1};
        vecs[12] = '{32, 64'h7FFFFFFF,   64'hFFFFFFFF,   1'b0, 1'b1, 64'h80000000,   1'b0, 1'b1, 1'b0};

        i16.in_valid = 1'b0; i16.x = '0; i16.y = '0; i16.cin = 1'b0; i16.sub = 1'b0; i16.out_ready = 1'b1;
        i32.in_valid = 1'b0; i32.x = '0; i32.y = '0; i32.cin = 1'b0; i32.sub = 1'b0; i32.out_ready = 1'b1;
        i64.in_valid = 1'b0; i64.x = '0; i64.y = '0; i64.cin = 1'b0; i64.sub = 1'b0; i64.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst16_out_valid", 67'(i16.out_valid), 67'd0);
        chk("rst16_s_zero_in_ready", {i16.s, i16.zero, i16.in_ready}, {16'd0, 1'b1, 1'b1});
        chk("rst32_out_valid", 67'(i32.out_valid), 67'd0);
        chk("rst64_state", {i64.out_valid, i64.cout, i64.ovf, i64.zero, i64.in_ready},
            {1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
        chk("rst64_s", 67'(i64.s), 67'd0);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < NVEC; i++) apply_vec(vecs[i], i);

        // Back-pressure: 3 operand sets offered with out_ready low, only 2 may enter
        bx[0] = 64'h0123456789ABCDEF; by[0] = 64'h1111111111111111; bsub[0] = 1'b0;
        bx[1] = 64'h0000000000000005; by[1] = 64'h0000000000000007; bsub[1] = 1'b1;
        bx[2] = 64'hFFFFFFFFFFFFFFFF; by[2] = 64'h0000000000000001; bsub[2] = 1'b0;
        exp_q.delete();
        n_out = 0;
        idx = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            step64(idx < 3, bx[idx % 3], by[idx % 3], 1'b0, bsub[idx % 3], 1'b0, acc);
            if (acc) idx++;
        end
        chk("bp_accepted", 67'(idx), 67'd2);
        chk("bp_in_ready_low", 67'(i64.in_ready), 67'd0);
        chk("bp_out_valid", 67'(i64.out_valid), 67'd1);
        chk("bp_hold_a", {i64.ovf, i64.zero, i64.cout, i64.s}, model64(bx[0], by[0], 1'b0, bsub[0]));
        step64(1'b1, bx[2], by[2], 1'b0, bsub[2], 1'b0, acc);
        chk("bp_hold_b", {i64.ovf, i64.zero, i64.cout, i64.s}, model64(bx[0], by[0], 1'b0, bsub[0]));
        for (int cyc = 0; cyc < 10 && (idx < 3 || exp_q.size() > 0); cyc++) begin
            step64(idx < 3, bx[idx % 3], by[idx % 3], 1'b0, bsub[idx % 3], 1'b1, acc);
            if (acc) idx++;
        end
        chk("bp_all_accepted", 67'(idx), 67'd3);
        chk("bp_all_out", 67'(n_out), 67'd3);

        // Random streaming with random out_ready against the model
        exp_q.delete();
        n_out = 0;
        sent = 0;
        have = 1'b0;
        rx = '0; ry = '0; rcin = 1'b0; rsub = 1'b0;
        for (int cyc = 0; cyc < 60000 && sent < NSTREAM; cyc++) begin
            if (!have) begin
                rx = {$urandom(), $urandom()};
                ry = {$urandom(), $urandom()};
                case ($urandom_range(0, 7))
                    0: rx = '1;
                    1: ry = ~rx;
                    2: ry = rx;
                    default: ;
                endcase
                rcin = 1'($urandom_range(0, 1));
                rsub = 1'($urandom_range(0, 1));
                have = 1'b1;
            end
            step64(1'b1, rx, ry, rcin, rsub, 1'($urandom_range(0, 1)), acc);
            if (acc) begin
                sent++;
                have = 1'b0;
            end
        end
        for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) step64(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        chk("stream_sent", 67'(sent), 67'(NSTREAM));
        chk("stream_received", 67'(n_out), 67'(NSTREAM));

        // Reset mid-stream with both stages full
        exp_q.delete();
        n_out = 0;
        step64(1'b1, 64'h10, 64'h20, 1'b0, 1'b0, 1'b0, acc);
        step64(1'b1, 64'h30, 64'h40, 1'b0, 1'b0, 1'b0, acc);
        step64(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
        chk("mid_full_in_ready", 67'(i64.in_ready), 67'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_state", {i64.out_valid, i64.zero, i64.in_ready, i64.cout, i64.ovf},
            {1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        chk("mid_rst_s", 67'(i64.s), 67'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) step64(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
        chk("mid_no_stale", 67'(n_out), 67'd0);
        chk("mid_out_valid_idle", 67'(i64.out_valid), 67'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
